// File: rtl/spi_tx_pkg.sv
// Shared definitions for the SPI master transmitter: FSM state encoding
// and the bus word width used by the bus buffer, the top level and the SPI block.
package spi_tx_pkg;

  typedef enum logic [2:0] {
    SPI_IDLE  = 3'd0,
    SPI_SETUP = 3'd1,
    SPI_SHIFT = 3'd2,
    SPI_HOLD  = 3'd3,
    SPI_GAP   = 3'd4
  } spi_state_e;

  localparam int SPI_DATA_WIDTH = 24;

endpackage

// File: rtl/spi_tx_clk_gen.sv
// SCLK generator for the SPI transmitter. While enabled, a divider counts
// 0..CLK_DIV-1 and SCLK toggles at the terminal count. The rise/fall strobes
// flag the cycle in which SCLK is about to change, so the parent can update
// its shift state on the same edge. Disabled means SCLK parked low.
module spi_tx_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic RSTn,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);

  logic [DIV_W-1:0] div_r;
  logic             sclk_r;
  logic             tc_s;

  assign tc_s = en & (div_r == DIV_LAST);
  assign rise = tc_s & ~sclk_r;
  assign fall = tc_s & sclk_r;
  assign sclk = sclk_r;

  // Divider counter and SCLK toggle flop; idle low whenever not enabled.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      div_r  <= DIV_ZERO;
      sclk_r <= 1'b0;
    end else if (!en) begin
      div_r  <= DIV_ZERO;
      sclk_r <= 1'b0;
    end else if (tc_s) begin
      div_r  <= DIV_ZERO;
      sclk_r <= ~sclk_r;
    end else begin
      div_r  <= div_r + DIV_ONE;
    end
  end

endmodule

// File: rtl/spi_tx.sv
// SPI master transmitter, mode 0, MSB first. Captures a word from the bus
// buffer, holds spi_ready for the whole frame, then drops it and waits out a
// guard gap so the buffer can retire the word before bus_valid is looked at again.
module spi_tx
  import spi_tx_pkg::*;
#(
  parameter int DATA_WIDTH = SPI_DATA_WIDTH,
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  RSTn,
  input  logic                  bus_valid,
  input  logic [DATA_WIDTH-1:0] BUS_DATA,
  output logic                  spi_ready,
  output logic                  tx_done,
  output logic                  SPI_SCLK,
  output logic                  SPI_CS_N,
  output logic                  SPI_MOSI
);

  localparam int PH_W  = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(DATA_WIDTH + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_ONE   = PH_W'(1);
  localparam logic [PH_W-1:0]  PH_ZERO  = PH_W'(0);
  localparam logic [BIT_W-1:0] BIT_FULL = BIT_W'(DATA_WIDTH);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [BIT_W-1:0] BIT_ZERO = BIT_W'(0);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [GAP_W-1:0] GAP_ZERO = GAP_W'(0);

  spi_state_e            state_r, state_nxt_s;
  logic [DATA_WIDTH-1:0] shreg_r, shreg_nxt_s;
  logic [PH_W-1:0]       phase_r, phase_nxt_s;
  logic [BIT_W-1:0]      bit_cnt_r, bit_cnt_nxt_s;
  logic [GAP_W-1:0]      gap_r, gap_nxt_s;
  logic                  ready_r, ready_nxt_s;
  logic                  cs_n_r, cs_n_nxt_s;
  logic                  mosi_r, mosi_nxt_s;
  logic                  done_r, done_nxt_s;
  logic                  shift_en_s;
  logic                  sclk_s, rise_s, fall_s;

  assign shift_en_s = (state_r == SPI_SHIFT);

  spi_tx_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk  (clk),
    .RSTn (RSTn),
    .en   (shift_en_s),
    .sclk (sclk_s),
    .rise (rise_s),
    .fall (fall_s)
  );

  assign spi_ready = ready_r;
  assign tx_done   = done_r;
  assign SPI_SCLK  = sclk_s;
  assign SPI_CS_N  = cs_n_r;
  assign SPI_MOSI  = mosi_r;

  // Next-state and next-output decode for the frame sequencer.
  always_comb begin
    state_nxt_s   = state_r;
    shreg_nxt_s   = shreg_r;
    phase_nxt_s   = phase_r;
    bit_cnt_nxt_s = bit_cnt_r;
    gap_nxt_s     = gap_r;
    ready_nxt_s   = ready_r;
    cs_n_nxt_s    = cs_n_r;
    mosi_nxt_s    = mosi_r;
    done_nxt_s    = 1'b0;
    case (state_r)
      SPI_IDLE: begin
        if (bus_valid) begin
          shreg_nxt_s   = BUS_DATA;
          ready_nxt_s   = 1'b1;
          cs_n_nxt_s    = 1'b0;
          mosi_nxt_s    = BUS_DATA[DATA_WIDTH-1];
          phase_nxt_s   = PH_ZERO;
          bit_cnt_nxt_s = BIT_ZERO;
          state_nxt_s   = SPI_SETUP;
        end else begin
          state_nxt_s   = SPI_IDLE;
        end
      end
      SPI_SETUP: begin
        if (phase_r == PH_LAST) begin
          phase_nxt_s = PH_ZERO;
          state_nxt_s = SPI_SHIFT;
        end else begin
          phase_nxt_s = phase_r + PH_ONE;
        end
      end
      SPI_SHIFT: begin
        if (rise_s) begin
          bit_cnt_nxt_s = bit_cnt_r + BIT_ONE;
        end else if (fall_s) begin
          shreg_nxt_s = {shreg_r[DATA_WIDTH-2:0], 1'b0};
          mosi_nxt_s  = shreg_r[DATA_WIDTH-2];
          if (bit_cnt_r == BIT_FULL) begin
            phase_nxt_s = PH_ZERO;
            state_nxt_s = SPI_HOLD;
          end else begin
            state_nxt_s = SPI_SHIFT;
          end
        end else begin
          state_nxt_s = SPI_SHIFT;
        end
      end
      SPI_HOLD: begin
        if (phase_r == PH_LAST) begin
          cs_n_nxt_s  = 1'b1;
          ready_nxt_s = 1'b0;
          done_nxt_s  = 1'b1;
          mosi_nxt_s  = 1'b0;
          gap_nxt_s   = GAP_ZERO;
          state_nxt_s = SPI_GAP;
        end else begin
          phase_nxt_s = phase_r + PH_ONE;
        end
      end
      SPI_GAP: begin
        // bus_valid is ignored here while the buffer retires the old word.
        if (gap_r == GAP_LAST) begin
          gap_nxt_s   = GAP_ZERO;
          state_nxt_s = SPI_IDLE;
        end else begin
          gap_nxt_s   = gap_r + GAP_ONE;
        end
      end
      default: begin
        state_nxt_s = SPI_IDLE;
        ready_nxt_s = 1'b0;
        cs_n_nxt_s  = 1'b1;
        mosi_nxt_s  = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_r <= SPI_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath registers: shift register, counters and all serial/handshake outputs.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      shreg_r   <= {DATA_WIDTH{1'b0}};
      phase_r   <= PH_ZERO;
      bit_cnt_r <= BIT_ZERO;
      gap_r     <= GAP_ZERO;
      ready_r   <= 1'b0;
      cs_n_r    <= 1'b1;
      mosi_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      shreg_r   <= shreg_nxt_s;
      phase_r   <= phase_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      gap_r     <= gap_nxt_s;
      ready_r   <= ready_nxt_s;
      cs_n_r    <= cs_n_nxt_s;
      mosi_r    <= mosi_nxt_s;
      done_r    <= done_nxt_s;
    end
  end

endmodule

// File: tb/tb_spi_tx.sv
// Self-checking bench for spi_tx: a default instance (CLK_DIV=4) and a
// CLK_DIV=1 instance. A line monitor decodes each frame from the pins
// (MOSI at SCLK rise, framed by CS_N) and the tests compare against words
// and frame timings derived from the protocol rules.
module tb_spi_tx;

  localparam int DW   = 24;
  localparam int DIV0 = 4;
  localparam int DIV1 = 1;
  localparam int GAP  = 3;
  localparam int LEN0 = (2 * DW + 2) * DIV0;
  localparam int LEN1 = (2 * DW + 2) * DIV1;

  logic          clk = 1'b0;
  logic          RSTn;
  logic [1:0]    bv;
  logic [DW-1:0] bd [2];
  logic [1:0]    sr, td, sc, cs, mo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_tx #(.DATA_WIDTH(DW), .CLK_DIV(DIV0), .GAP_CYCLES(GAP)) dut0 (
    .clk(clk), .RSTn(RSTn), .bus_valid(bv[0]), .BUS_DATA(bd[0]),
    .spi_ready(sr[0]), .tx_done(td[0]), .SPI_SCLK(sc[0]), .SPI_CS_N(cs[0]), .SPI_MOSI(mo[0]));

  spi_tx #(.DATA_WIDTH(DW), .CLK_DIV(DIV1), .GAP_CYCLES(GAP)) dut1 (
    .clk(clk), .RSTn(RSTn), .bus_valid(bv[1]), .BUS_DATA(bd[1]),
    .spi_ready(sr[1]), .tx_done(td[1]), .SPI_SCLK(sc[1]), .SPI_CS_N(cs[1]), .SPI_MOSI(mo[1]));

  // Line monitor state, per instance
  logic [DW-1:0] acc [2];
  int bits [2], cs_cnt [2], rdy_cnt [2], hi_cnt [2];
  logic prev_sclk [2], prev_cs [2], prev_rdy [2];
  int frame_cnt [2] = '{0, 0};
  int done_cnt [2] = '{0, 0};
  int last_bits [2], last_cs_low [2], last_rdy_len [2];
  logic [DW-1:0] rx_log [2][16];
  int gap_log [2][16];

  // Decode frames from the pins; reset abandons any partial frame.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!RSTn) begin
        acc[i] <= '0; bits[i] <= 0; cs_cnt[i] <= 0; rdy_cnt[i] <= 0; hi_cnt[i] <= 0;
        prev_sclk[i] <= 1'b0; prev_cs[i] <= 1'b1; prev_rdy[i] <= 1'b0;
      end else begin
        prev_sclk[i] <= sc[i]; prev_cs[i] <= cs[i]; prev_rdy[i] <= sr[i];
        if (sc[i] && !prev_sclk[i]) begin
          acc[i]  <= {acc[i][DW-2:0], mo[i]};
          bits[i] <= bits[i] + 1;
        end
        if (!cs[i]) cs_cnt[i] <= cs_cnt[i] + 1;
        if (cs[i] && !prev_cs[i]) begin
          rx_log[i][frame_cnt[i][3:0]] <= acc[i];
          last_bits[i]   <= bits[i];
          last_cs_low[i] <= cs_cnt[i];
          frame_cnt[i]   <= frame_cnt[i] + 1;
          acc[i] <= '0; bits[i] <= 0; cs_cnt[i] <= 0; hi_cnt[i] <= 1;
        end else if (cs[i]) begin
          hi_cnt[i] <= hi_cnt[i] + 1;
        end
        if (!cs[i] && prev_cs[i]) gap_log[i][frame_cnt[i][3:0]] <= hi_cnt[i];
        if (sr[i]) rdy_cnt[i] <= rdy_cnt[i] + 1;
        if (!sr[i] && prev_rdy[i]) begin
          last_rdy_len[i] <= rdy_cnt[i];
          rdy_cnt[i] <= 0;
        end
        if (td[i]) done_cnt[i] <= done_cnt[i] + 1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_ready(input int i);
    int n = 0;
    while (!sr[i] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!sr[i]) begin
      checks++; errors++;
      $display("FAIL ready_timeout dut%0d: spi_ready got 0 want 1", i);
    end
  endtask

  task automatic wait_done(input int i, input int start, input int budget);
    int n = 0;
    while (done_cnt[i] == start && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt[i] == start) begin
      checks++; errors++;
      $display("FAIL done_timeout dut%0d: no tx_done within %0d cycles", i, budget);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    RSTn = 1'b0; bv = 2'b00; bd[0] = '0; bd[1] = '0;
    repeat (3) @(negedge clk);
    checks++; if (sr !== 2'b00) begin errors++; $display("FAIL rst_ready got %b want 00", sr); end
    checks++; if (td !== 2'b00) begin errors++; $display("FAIL rst_done got %b want 00", td); end
    checks++; if (sc !== 2'b00) begin errors++; $display("FAIL rst_sclk got %b want 00", sc); end
    checks++; if (cs !== 2'b11) begin errors++; $display("FAIL rst_csn got %b want 11", cs); end
    checks++; if (mo !== 2'b00) begin errors++; $display("FAIL rst_mosi got %b want 00", mo); end
    RSTn = 1'b1;
  endtask

  task automatic test_idle();
    int bad_sclk = 0, bad_cs = 0, bad_rdy = 0;
    int dc = done_cnt[0];
    bv[0] = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      bd[0] = DW'($urandom);
      if (sc[0] !== 1'b0) bad_sclk++;
      if (cs[0] !== 1'b1) bad_cs++;
      if (sr[0] !== 1'b0) bad_rdy++;
    end
    checks++; if (bad_sclk != 0) begin errors++; $display("FAIL idle_sclk got %0d high cycles want 0", bad_sclk); end
    checks++; if (bad_cs != 0) begin errors++; $display("FAIL idle_csn got %0d low cycles want 0", bad_cs); end
    checks++; if (bad_rdy != 0) begin errors++; $display("FAIL idle_ready got %0d high cycles want 0", bad_rdy); end
    checks++; if (done_cnt[0] != dc) begin errors++; $display("FAIL idle_done got %0d pulses want 0", done_cnt[0] - dc); end
  endtask

  task automatic test_single_frames();
    logic [DW-1:0] words [5];
    words[0] = 24'hA5C3F0;
    for (int k = 1; k < 5; k++) words[k] = DW'($urandom);
    for (int k = 0; k < 5; k++) begin
      int fc = frame_cnt[0];
      int dc = done_cnt[0];
      bd[0] = words[k]; bv[0] = 1'b1;
      wait_ready(0);
      bv[0] = 1'b0; bd[0] = DW'($urandom);
      wait_done(0, dc, 2 * LEN0);
      checks++; if (frame_cnt[0] != fc + 1) begin errors++; $display("FAIL single_frames got %0d want %0d", frame_cnt[0] - fc, 1); end
      checks++; if (rx_log[0][fc[3:0]] !== words[k]) begin errors++; $display("FAIL single_word got %h want %h", rx_log[0][fc[3:0]], words[k]); end
      checks++; if (last_bits[0] != DW) begin errors++; $display("FAIL single_bits got %0d want %0d", last_bits[0], DW); end
      checks++; if (last_cs_low[0] != LEN0) begin errors++; $display("FAIL single_csn_low got %0d want %0d", last_cs_low[0], LEN0); end
      checks++; if (last_rdy_len[0] != LEN0) begin errors++; $display("FAIL single_ready_len got %0d want %0d", last_rdy_len[0], LEN0); end
      checks++; if (done_cnt[0] != dc + 1) begin errors++; $display("FAIL single_done got %0d want 1", done_cnt[0] - dc); end
    end
  endtask

  task automatic test_mid_change();
    int fc = frame_cnt[0];
    int dc = done_cnt[0];
    bd[0] = 24'h123456; bv[0] = 1'b1;
    wait_ready(0);
    bd[0] = 24'hFFFFFF;
    repeat (50) @(negedge clk);
    bv[0] = 1'b0;
    wait_done(0, dc, 2 * LEN0);
    repeat (10) @(negedge clk);
    checks++; if (frame_cnt[0] != fc + 1) begin errors++; $display("FAIL mid_frames got %0d want 1", frame_cnt[0] - fc); end
    checks++; if (rx_log[0][fc[3:0]] !== 24'h123456) begin errors++; $display("FAIL mid_word got %h want 123456", rx_log[0][fc[3:0]]); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] q [$];
    logic [DW-1:0] exp [4];
    int fc = frame_cnt[0];
    int dc = done_cnt[0];
    int n = 0;
    logic pr = 1'b0;
    exp[0] = 24'h000001; exp[1] = 24'h800000; exp[2] = DW'($urandom); exp[3] = DW'($urandom);
    for (int k = 0; k < 4; k++) q.push_back(exp[k]);
    bv[0] = 1'b1; bd[0] = q[0];
    while (q.size() > 0 && n < 6 * LEN0) begin
      @(negedge clk);
      n++;
      if (pr && !sr[0]) void'(q.pop_front());
      pr = sr[0];
      bv[0] = (q.size() > 0);
      bd[0] = (q.size() > 0) ? q[0] : DW'($urandom);
    end
    bv[0] = 1'b0;
    if (q.size() > 0) begin
      checks++; errors++;
      $display("FAIL b2b_timeout got %0d words left want 0", q.size());
    end
    repeat (10) @(negedge clk);
    checks++; if (frame_cnt[0] != fc + 4) begin errors++; $display("FAIL b2b_frames got %0d want 4", frame_cnt[0] - fc); end
    checks++; if (done_cnt[0] != dc + 4) begin errors++; $display("FAIL b2b_done got %0d want 4", done_cnt[0] - dc); end
    for (int k = 0; k < 4; k++) begin
      int idx = fc + k;
      checks++; if (rx_log[0][idx[3:0]] !== exp[k]) begin errors++; $display("FAIL b2b_word%0d got %h want %h", k, rx_log[0][idx[3:0]], exp[k]); end
      if (k > 0) begin
        checks++; if (gap_log[0][idx[3:0]] != GAP + 1) begin errors++; $display("FAIL b2b_gap%0d got %0d want %0d", k, gap_log[0][idx[3:0]], GAP + 1); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] w1 = DW'($urandom);
    logic [DW-1:0] w2 = DW'($urandom);
    int fc = frame_cnt[0];
    int dc = done_cnt[0];
    int nr = 0, n = 0;
    logic ps = 1'b0;
    bd[0] = w1; bv[0] = 1'b1;
    while (nr < 10 && n < 2 * LEN0) begin
      @(negedge clk);
      n++;
      if (sc[0] && !ps) nr++;
      ps = sc[0];
    end
    if (nr < 10) begin
      checks++; errors++;
      $display("FAIL rmid_timeout got %0d rises want 10", nr);
    end
    #1 RSTn = 1'b0; bd[0] = w2;
    #1;
    checks++; if (cs[0] !== 1'b1) begin errors++; $display("FAIL rmid_csn got %b want 1", cs[0]); end
    checks++; if (sc[0] !== 1'b0) begin errors++; $display("FAIL rmid_sclk got %b want 0", sc[0]); end
    checks++; if (sr[0] !== 1'b0) begin errors++; $display("FAIL rmid_ready got %b want 0", sr[0]); end
    repeat (3) @(negedge clk);
    RSTn = 1'b1;
    wait_ready(0);
    bv[0] = 1'b0;
    wait_done(0, dc, 2 * LEN0);
    checks++; if (frame_cnt[0] != fc + 1) begin errors++; $display("FAIL rmid_frames got %0d want 1", frame_cnt[0] - fc); end
    checks++; if (rx_log[0][fc[3:0]] !== w2) begin errors++; $display("FAIL rmid_word got %h want %h", rx_log[0][fc[3:0]], w2); end
    checks++; if (last_bits[0] != DW) begin errors++; $display("FAIL rmid_bits got %0d want %0d", last_bits[0], DW); end
    checks++; if (done_cnt[0] != dc + 1) begin errors++; $display("FAIL rmid_done got %0d want 1", done_cnt[0] - dc); end
  endtask

  task automatic test_div1();
    int fc = frame_cnt[1];
    int dc = done_cnt[1];
    int n = 0, cyc = 0, nrise = 0, min_p = 1000, max_p = 0;
    logic ps = 1'b0;
    logic [DW-1:0] w;
    bd[1] = 24'h800001; bv[1] = 1'b1;
    wait_ready(1);
    bv[1] = 1'b0;
    while (done_cnt[1] == dc && n < 4 * LEN1) begin
      @(negedge clk);
      n++; cyc++;
      if (sc[1] && !ps) begin
        if (nrise > 0) begin
          if (cyc < min_p) min_p = cyc;
          if (cyc > max_p) max_p = cyc;
        end
        nrise++; cyc = 0;
      end
      ps = sc[1];
    end
    wait_done(1, dc, 4);
    w = rx_log[1][fc[3:0]];
    checks++; if (frame_cnt[1] != fc + 1) begin errors++; $display("FAIL div1_frames got %0d want 1", frame_cnt[1] - fc); end
    checks++; if (min_p != 2 || max_p != 2) begin errors++; $display("FAIL div1_sclk_period got %0d..%0d want 2", min_p, max_p); end
    checks++; if (last_rdy_len[1] != LEN1) begin errors++; $display("FAIL div1_ready_len got %0d want %0d", last_rdy_len[1], LEN1); end
    checks++; if (last_cs_low[1] != LEN1) begin errors++; $display("FAIL div1_csn_low got %0d want %0d", last_cs_low[1], LEN1); end
    checks++; if (w[DW-1] !== 1'b1) begin errors++; $display("FAIL div1_first_bit got %b want 1", w[DW-1]); end
    checks++; if (w[0] !== 1'b1) begin errors++; $display("FAIL div1_last_bit got %b want 1", w[0]); end
    checks++; if (w !== 24'h800001) begin errors++; $display("FAIL div1_word got %h want 800001", w); end
    checks++; if (last_bits[1] != DW) begin errors++; $display("FAIL div1_bits got %0d want %0d", last_bits[1], DW); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single_frames();
    test_mid_change();
    test_back_to_back();
    test_reset_mid();
    test_div1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
